// File: rtl/timeout_event_fifo.sv
// Timestamps rising edges of the counter's timeout, tags them with direction and count,
// and queues them in a show-ahead FIFO popped over valid/ready, with overflow accounting.
module timeout_event_fifo #(
  parameter int CNT_WIDTH   = 4,
  parameter int DEPTH       = 4,
  parameter int STAMP_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   timeout,
  input  logic [CNT_WIDTH-1:0]   cntout,
  input  logic                   dn_up,
  input  logic                   ev_ready,
  input  logic                   clr_ovf,
  output logic                   ev_valid,
  output logic [STAMP_WIDTH-1:0] ev_stamp,
  output logic                   ev_dir,
  output logic [CNT_WIDTH-1:0]   ev_cnt,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   ovf,
  output logic [7:0]             drop_cnt
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef struct packed {
    logic [STAMP_WIDTH-1:0] stamp;
    logic                   dir;
    logic [CNT_WIDTH-1:0]   cnt;
  } entry_t;

  logic [STAMP_WIDTH-1:0] stamp_q, stamp_d;
  logic                   timeout_q, timeout_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]       level_q, level_d;
  logic                   ovf_q, ovf_d;
  logic [7:0]             drop_cnt_q, drop_cnt_d;
  entry_t                 mem_q [DEPTH];
  entry_t                 wr_entry;
  entry_t                 head;
  logic                   ev_det, pop, push, drop;
  logic                   not_empty, is_full;

  always_comb begin
    not_empty = (level_q != '0);
    is_full   = (level_q == LVL_W'(DEPTH));
    ev_det    = timeout & ~timeout_q;
    pop       = not_empty & ev_ready;
    // A full FIFO still accepts an event when the head leaves in the same cycle.
    push      = ev_det & (~is_full | pop);
    drop      = ev_det & is_full & ~pop;

    wr_entry.stamp = stamp_q;
    wr_entry.dir   = dn_up;
    wr_entry.cnt   = cntout;

    stamp_d   = stamp_q + STAMP_WIDTH'(1);
    timeout_d = timeout;
    wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d   = level_q + LVL_W'(push) - LVL_W'(pop);

    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    if (clr_ovf) begin
      ovf_d      = 1'b0;
      drop_cnt_d = '0;
    end
    // Applied after the clear so a same-cycle drop leaves ovf=1, drop_cnt=1.
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_cnt_d != 8'hFF) drop_cnt_d = drop_cnt_d + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stamp_q    <= '0;
      timeout_q  <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      stamp_q    <= stamp_d;
      timeout_q  <= timeout_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) mem_q[wr_ptr_q] <= wr_entry;
  end

  always_comb begin
    head     = mem_q[rd_ptr_q];
    ev_valid = not_empty;
    ev_stamp = not_empty ? head.stamp : '0;
    ev_dir   = not_empty ? head.dir   : 1'b0;
    ev_cnt   = not_empty ? head.cnt   : '0;
    level    = level_q;
    full     = is_full;
    ovf      = ovf_q;
    drop_cnt = drop_cnt_q;
  end

endmodule

// File: tb/tb_timeout_event_fifo.sv
// Directed table-driven bench for timeout_event_fifo plus hand sequences for
// saturation, clear/drop collision, stamp wrap and mid-run reset.
module tb_timeout_event_fifo;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       timeout = 1'b1;
  logic [3:0] cntout = '0;
  logic       dn_up = 1'b0;
  logic       ev_ready = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       ev_valid;
  logic [7:0] ev_stamp;
  logic       ev_dir;
  logic [3:0] ev_cnt;
  logic [2:0] level;
  logic       full;
  logic       ovf;
  logic [7:0] drop_cnt;

  int checks = 0;
  int errors = 0;
  logic [7:0] mstamp = '0;

  timeout_event_fifo #(.CNT_WIDTH(4), .DEPTH(4), .STAMP_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .timeout(timeout), .cntout(cntout), .dn_up(dn_up),
    .ev_ready(ev_ready), .clr_ovf(clr_ovf), .ev_valid(ev_valid), .ev_stamp(ev_stamp),
    .ev_dir(ev_dir), .ev_cnt(ev_cnt), .level(level), .full(full), .ovf(ovf),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, to, dir; logic [3:0] cnt; logic rdy, clr; int rep;
    logic vld; logic [7:0] stamp; logic edir; logic [3:0] ecnt;
    logic [2:0] lvl; logic efull, eovf; logic [7:0] edrop;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic r, t, d, input logic [3:0] c, input logic rd, cl,
                     input int rep, input logic v, input logic [7:0] s, input logic ed,
                     input logic [3:0] ec, input logic [2:0] l, input logic f, o,
                     input logic [7:0] dc);
    vec_t x;
    x = '{r, t, d, c, rd, cl, rep, v, s, ed, ec, l, f, o, dc};
    vecs.push_back(x);
  endtask

  // Drive inputs at the falling edge, let one rising edge pass, sample 1 time unit later.
  task automatic step(input logic r, t, d, input logic [3:0] c, input logic rd, cl);
    @(negedge clk);
    reset = r; timeout = t; dn_up = d; cntout = c; ev_ready = rd; clr_ovf = cl;
    @(posedge clk);
    mstamp = r ? 8'h00 : mstamp + 8'h01;
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic v, input logic [7:0] s,
                            input logic ed, input logic [3:0] ec, input logic [2:0] l,
                            input logic f, o, input logic [7:0] dc);
    chk({tag, ".ev_valid"}, 32'(ev_valid), 32'(v));
    chk({tag, ".ev_stamp"}, 32'(ev_stamp), 32'(s));
    chk({tag, ".ev_dir"},   32'(ev_dir),   32'(ed));
    chk({tag, ".ev_cnt"},   32'(ev_cnt),   32'(ec));
    chk({tag, ".level"},    32'(level),    32'(l));
    chk({tag, ".full"},     32'(full),     32'(f));
    chk({tag, ".ovf"},      32'(ovf),      32'(o));
    chk({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(dc));
  endtask

  initial begin
    //   rst to dir cnt  rdy clr rep | vld stamp dir cnt lvl full ovf drop
    add(1, 1, 0, 4'h0, 0, 0, 3,  0, 8'h00, 0, 4'h0, 0, 0, 0, 0);  // reset, timeout high
    add(0, 1, 0, 4'h0, 0, 0, 1,  0, 8'h00, 0, 4'h0, 0, 0, 0, 0);  // release: no event
    add(0, 0, 0, 4'h0, 0, 0, 17, 0, 8'h00, 0, 4'h0, 0, 0, 0, 0);  // stamp -> 0x12
    add(0, 1, 1, 4'hF, 0, 0, 1,  1, 8'h12, 1, 4'hF, 1, 0, 0, 0);  // edge at 0x12
    add(0, 1, 0, 4'h3, 0, 0, 5,  1, 8'h12, 1, 4'hF, 1, 0, 0, 0);  // held high: one event
    add(0, 0, 0, 4'h0, 1, 0, 1,  0, 8'h00, 0, 4'h0, 0, 0, 0, 0);  // pop -> empty
    add(0, 1, 1, 4'h1, 0, 0, 1,  1, 8'h19, 1, 4'h1, 1, 0, 0, 0);
    add(0, 0, 0, 4'h0, 0, 0, 1,  1, 8'h19, 1, 4'h1, 1, 0, 0, 0);
    add(0, 1, 0, 4'h2, 0, 0, 1,  1, 8'h19, 1, 4'h1, 2, 0, 0, 0);
    add(0, 0, 0, 4'h0, 0, 0, 1,  1, 8'h19, 1, 4'h1, 2, 0, 0, 0);
    add(0, 1, 1, 4'h3, 0, 0, 1,  1, 8'h19, 1, 4'h1, 3, 0, 0, 0);
    add(0, 0, 0, 4'h0, 0, 0, 1,  1, 8'h19, 1, 4'h1, 3, 0, 0, 0);
    add(0, 1, 0, 4'h4, 0, 0, 1,  1, 8'h19, 1, 4'h1, 4, 1, 0, 0);
    add(0, 0, 0, 4'h0, 0, 0, 1,  1, 8'h19, 1, 4'h1, 4, 1, 0, 0);
    add(0, 1, 1, 4'h5, 0, 0, 1,  1, 8'h19, 1, 4'h1, 4, 1, 1, 1);  // fifth pulse dropped
    add(0, 0, 0, 4'h0, 1, 0, 1,  1, 8'h1B, 0, 4'h2, 3, 0, 1, 1);
    add(0, 0, 0, 4'h0, 1, 0, 1,  1, 8'h1D, 1, 4'h3, 2, 0, 1, 1);
    add(0, 0, 0, 4'h0, 1, 0, 1,  1, 8'h1F, 0, 4'h4, 1, 0, 1, 1);
    add(0, 0, 0, 4'h0, 1, 0, 1,  0, 8'h00, 0, 4'h0, 0, 0, 1, 1);
    add(0, 0, 0, 4'h0, 0, 1, 1,  0, 8'h00, 0, 4'h0, 0, 0, 0, 0);  // clear
    add(0, 1, 1, 4'h6, 0, 0, 1,  1, 8'h27, 1, 4'h6, 1, 0, 0, 0);
    add(0, 0, 0, 4'h0, 0, 0, 1,  1, 8'h27, 1, 4'h6, 1, 0, 0, 0);
    add(0, 1, 0, 4'h7, 0, 0, 1,  1, 8'h27, 1, 4'h6, 2, 0, 0, 0);
    add(0, 0, 0, 4'h0, 0, 0, 1,  1, 8'h27, 1, 4'h6, 2, 0, 0, 0);
    add(0, 1, 1, 4'h8, 0, 0, 1,  1, 8'h27, 1, 4'h6, 3, 0, 0, 0);
    add(0, 0, 0, 4'h0, 0, 0, 1,  1, 8'h27, 1, 4'h6, 3, 0, 0, 0);
    add(0, 1, 0, 4'h9, 0, 0, 1,  1, 8'h27, 1, 4'h6, 4, 1, 0, 0);
    add(0, 0, 0, 4'h0, 0, 0, 1,  1, 8'h27, 1, 4'h6, 4, 1, 0, 0);
    add(0, 1, 1, 4'hA, 1, 0, 1,  1, 8'h29, 0, 4'h7, 4, 1, 0, 0);  // full + pop + edge
    add(0, 0, 0, 4'h0, 1, 0, 1,  1, 8'h2B, 1, 4'h8, 3, 0, 0, 0);
    add(0, 0, 0, 4'h0, 1, 0, 1,  1, 8'h2D, 0, 4'h9, 2, 0, 0, 0);
    add(0, 0, 0, 4'h0, 1, 0, 1,  1, 8'h2F, 1, 4'hA, 1, 0, 0, 0);
    add(0, 0, 0, 4'h0, 1, 0, 1,  0, 8'h00, 0, 4'h0, 0, 0, 0, 0);
    add(0, 0, 0, 4'h0, 1, 0, 1,  0, 8'h00, 0, 4'h0, 0, 0, 0, 0);  // ready while empty

    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].rep; r++)
        step(vecs[i].rst, vecs[i].to, vecs[i].dir, vecs[i].cnt, vecs[i].rdy, vecs[i].clr);
      check_outs($sformatf("v%0d", i), vecs[i].vld, vecs[i].stamp, vecs[i].edir,
                 vecs[i].ecnt, vecs[i].lvl, vecs[i].efull, vecs[i].eovf, vecs[i].edrop);
    end

    // Drop saturation and clear/drop collision.
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1'(i), 4'(i), 0, 0);
      step(0, 0, 0, 4'h0, 0, 0);
    end
    chk("sat.fill_level", 32'(level), 32'd4);
    chk("sat.fill_head_cnt", 32'(ev_cnt), 32'd0);
    for (int i = 0; i < 260; i++) begin
      step(0, 1, 0, 4'h0, 0, 0);
      if (i == 0) chk("sat.first_drop", 32'(drop_cnt), 32'd1);
      if (i == 254) chk("sat.at_255", 32'(drop_cnt), 32'd255);
      step(0, 0, 0, 4'h0, 0, 0);
    end
    chk("sat.drop_cnt", 32'(drop_cnt), 32'd255);
    chk("sat.ovf", 32'(ovf), 32'd1);
    chk("sat.level", 32'(level), 32'd4);
    step(0, 1, 0, 4'h0, 0, 1);
    chk("clrdrop.ovf", 32'(ovf), 32'd1);
    chk("clrdrop.drop_cnt", 32'(drop_cnt), 32'd1);
    step(0, 0, 0, 4'h0, 0, 0);
    step(0, 0, 0, 4'h0, 0, 1);
    chk("clr.ovf", 32'(ovf), 32'd0);
    chk("clr.drop_cnt", 32'(drop_cnt), 32'd0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 4'h0, 1, 0);
    chk("drain.valid", 32'(ev_valid), 32'd0);
    chk("drain.level", 32'(level), 32'd0);

    // Stamp wrap: events at 0xFF and 0x02.
    for (int n = 0; n < 600 && mstamp != 8'hFF; n++) step(0, 0, 0, 4'h0, 0, 0);
    if (mstamp != 8'hFF) begin
      errors++;
      $display("FAIL wrap_wait: stamp model %0h never reached ff", mstamp);
    end
    step(0, 1, 1, 4'hC, 0, 0);
    check_outs("wrap1", 1, 8'hFF, 1, 4'hC, 1, 0, 0, 0);
    step(0, 0, 0, 4'h0, 0, 0);
    step(0, 0, 0, 4'h0, 0, 0);
    step(0, 1, 0, 4'hD, 0, 0);
    check_outs("wrap2", 1, 8'hFF, 1, 4'hC, 2, 0, 0, 0);
    step(0, 0, 0, 4'h0, 1, 0);
    check_outs("wrap3", 1, 8'h02, 0, 4'hD, 1, 0, 0, 0);
    step(0, 1, 1, 4'hE, 0, 0);
    chk("prerst.level", 32'(level), 32'd2);

    // Reset with two entries stored flushes everything.
    step(1, 1, 0, 4'h0, 0, 0);
    check_outs("rst", 0, 8'h00, 0, 4'h0, 0, 0, 0, 0);
    step(0, 0, 0, 4'h0, 0, 0);
    step(0, 1, 1, 4'h5, 0, 0);
    check_outs("postrst", 1, 8'h01, 1, 4'h5, 1, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/timeout_event_fifo.md
Name: timeout_event_fifo

Overview:
- Downstream consumer of the 4-bit up/down counter's `timeout` and `cntout` outputs.
- Detects each rising edge of `timeout` and timestamps it with a free-running cycle counter.
- Tags each event with the counting direction and count value, and buffers it in a small show-ahead FIFO.
- Presents buffered events on a valid/ready interface for a status or logging stage, and flags lost events when the buffer overflows.

Parameters:
- CNT_WIDTH, 4, width of the monitored counter value.
- DEPTH, 4, number of FIFO entries; must be a power of 2, at least 2.
- STAMP_WIDTH, 8, width of the free-running timestamp counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- timeout  in  1  timeout output of the counter stage; a level, edge-detected here.
- cntout  in  CNT_WIDTH  counter value from the counter stage.
- dn_up  in  1  counting direction driving the counter stage (1 = up, 0 = down).
- ev_ready  in  1  consumer accepts the head entry.
- clr_ovf  in  1  clears `ovf` and `drop_cnt`.
- ev_valid  out  1  FIFO not empty; the head entry is presented.
- ev_stamp  out  STAMP_WIDTH  timestamp of the head entry.
- ev_dir  out  1  `dn_up` captured with the head entry.
- ev_cnt  out  CNT_WIDTH  `cntout` captured with the head entry.
- level  out  clog2(DEPTH)+1  number of stored entries.
- full  out  1  level == DEPTH.
- ovf  out  1  sticky flag; an event was dropped.
- drop_cnt  out  8  saturating count of dropped events.

Behaviour:
- Reset (synchronous, active-high), applied at the next rising edge:
  - stamp = 0; read and write pointers = 0; level = 0; full = 0; ev_valid = 0.
  - ovf = 0; drop_cnt = 0.
  - timeout_q = 1, so a `timeout` level already high when reset is released does not create an event.
- Stamp counter:
  - Increments by 1 every cycle; wraps from 2^STAMP_WIDTH-1 to 0.
  - An event takes the stamp value present in its detection cycle.
- Edge detect:
  - timeout_q registers `timeout` every cycle.
  - ev_det = timeout & ~timeout_q, evaluated combinationally.
  - A `timeout` held high for many cycles gives exactly one event.
- Capture:
  - When ev_det = 1, the entry {stamp, dn_up, cntout} is sampled in that same cycle and written at the next edge.
  - ev_valid rises 1 cycle after the detection cycle if the FIFO was empty (1-cycle latency).
- Pop:
  - pop = ev_valid & ev_ready; the read pointer advances at the edge.
  - ev_ready while ev_valid = 0 has no effect.
- Output data:
  - Show-ahead; ev_stamp, ev_dir and ev_cnt reflect the head entry whenever ev_valid = 1.
  - They are driven 0 when the FIFO is empty.
- Write rules:
  - Not full: write.
  - Full with pop in the same cycle: write succeeds; level stays DEPTH.
  - Full without pop: drop the event; ovf <= 1; drop_cnt increments, saturating at 255.
- Simultaneous push and pop when not empty: level is unchanged.
- Empty FIFO with push: no bypass; the entry is visible 1 cycle later.
- Pointers wrap modulo DEPTH.
- level, full and ev_valid are registered state, or derived only from registered state.
- clr_ovf:
  - ovf <= 0 and drop_cnt <= 0.
  - If a drop occurs in the same cycle, the drop wins: ovf = 1, drop_cnt = 1.
- Reset mid-operation flushes all entries; ev_valid = 0 in the cycle after the reset edge.
- Inputs are synchronous to clk; no synchronizers are used.

Test Plan:
1. Reset held 3 cycles with `timeout` = 1 -> ev_valid = 0, level = 0, stamp = 0. Release with `timeout` still high -> no event; ev_valid stays 0.
2. `timeout` 0->1 when stamp = 0x12, dn_up = 1, cntout = 4'hF; ev_ready = 0 -> the next cycle gives ev_valid = 1, ev_stamp = 0x12, ev_dir = 1, ev_cnt = 4'hF, level = 1. Hold `timeout` high 5 cycles -> level stays 1.
3. Five separated `timeout` pulses with ev_ready = 0 -> level = 4, full = 1. Fifth pulse -> ovf = 1, drop_cnt = 1. Then ev_ready = 1 for 4 cycles -> entries pop in order with increasing stamps; ev_valid = 0 afterwards.
4. FIFO full with ev_ready = 1 in the same cycle as a new edge -> no drop, ovf stays 0, level stays 4. The new entry appears as the last entry popped.
5. 260 drops with the FIFO stalled -> drop_cnt = 255 (saturated). Assert clr_ovf in the same cycle as a drop -> ovf = 1, drop_cnt = 1. Assert clr_ovf alone -> ovf = 0, drop_cnt = 0.
6. Stamp wrap: event at stamp = 0xFF, next event 3 cycles later -> stamps 0xFF then 0x02. Assert reset with 2 entries stored -> ev_valid = 0 and level = 0 after the reset edge.
